// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32IM M-extension unit.
// Multiplies by WIDTH shift-add steps and divides by WIDTH restoring steps,
// both on unsigned magnitudes with a sign fix-up when the last step lands.
// Divide-by-zero and signed overflow bypass the iteration and finish at once.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic [WIDTH-1:0] Result,
  output logic             Busy,
  output logic             Done,
  output logic             Stall_CPU
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [2:0]             r_funct3;
  logic                   r_sign_a;
  logic                   r_sign_b;
  // Multiplicand for multiplies, divisor for divides.
  logic [WIDTH-1:0]       r_opnd;
  // Product for multiplies; low word is dividend/quotient shift register for divides.
  logic [2*WIDTH-1:0]     r_prod;
  logic [WIDTH:0]         r_rem;
  logic [WIDTH-1:0]       r_result;
  logic                   r_busy;
  logic                   r_done;

  // Operand decode in IDLE
  logic                   w_a_signed;
  logic                   w_b_signed;
  logic                   w_sign_a;
  logic                   w_sign_b;
  logic [WIDTH-1:0]       w_mag_a;
  logic [WIDTH-1:0]       w_mag_b;
  logic                   w_is_div_in;
  logic                   w_div_zero;
  logic                   w_div_ovf;
  logic [WIDTH-1:0]       w_special_res;

  // Iteration datapath
  logic [WIDTH:0]         w_add;
  logic [2*WIDTH-1:0]     w_mul_nxt;
  logic [WIDTH:0]         w_shift;
  logic [WIDTH:0]         w_diff;
  logic                   w_fit;
  logic [WIDTH:0]         w_rem_nxt;
  logic [WIDTH-1:0]       w_quo_nxt;
  logic                   w_last;

  // Sign fix-up applied to the unsigned iteration results.
  function automatic logic [WIDTH-1:0] f_finish(
    input logic [2:0]         f3,
    input logic [2*WIDTH-1:0] prod,
    input logic [WIDTH-1:0]   quo,
    input logic [WIDTH-1:0]   rem,
    input logic               sa,
    input logic               sb
  );
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   res;
    // The whole double-width product is negated so borrows from the low word
    // reach the high word correctly.
    p = (sa ^ sb) ? (~prod + 1'b1) : prod;
    case (f3)
      3'b000:  res = prod[WIDTH-1:0];
      3'b001,
      3'b010,
      3'b011:  res = p[2*WIDTH-1:WIDTH];
      3'b100,
      3'b101:  res = (sa ^ sb) ? (~quo + 1'b1) : quo;
      default: res = sa ? (~rem + 1'b1) : rem;
    endcase
    return res;
  endfunction

  // Signedness per opcode; unsigned operands keep their sign flags at zero so
  // the fix-up logic is uniform across all eight opcodes.
  always_comb begin
    w_a_signed    = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                    (Funct3 == 3'b100) || (Funct3 == 3'b110);
    w_b_signed    = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    w_sign_a      = w_a_signed & OperandA[WIDTH-1];
    w_sign_b      = w_b_signed & OperandB[WIDTH-1];
    w_mag_a       = w_sign_a ? (~OperandA + 1'b1) : OperandA;
    w_mag_b       = w_sign_b ? (~OperandB + 1'b1) : OperandB;
    w_is_div_in   = Funct3[2];
    w_div_zero    = w_is_div_in && (OperandB == '0);
    w_div_ovf     = w_is_div_in && !Funct3[0] &&
                    (OperandA == {1'b1, {(WIDTH-1){1'b0}}}) && (OperandB == '1);
    if (w_div_zero)
      w_special_res = Funct3[1] ? OperandA : '1;
    else
      w_special_res = Funct3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
  end

  // One shift-add step and one restoring-divide step, selected in CALC.
  always_comb begin
    w_add     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    w_mul_nxt = r_prod[0] ? {w_add, r_prod[WIDTH-1:1]}
                          : {1'b0, r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1:1]};
    // The partial remainder never reaches the divisor, so its top bit is zero
    // after every step; folding it in keeps the full register in the path.
    w_shift   = {r_rem[WIDTH-1:0], r_prod[WIDTH-1]} | {r_rem[WIDTH], {WIDTH{1'b0}}};
    w_diff    = w_shift - {1'b0, r_opnd};
    w_fit     = ~w_diff[WIDTH];
    w_rem_nxt = w_fit ? w_diff : w_shift;
    w_quo_nxt = {r_prod[WIDTH-2:0], w_fit};
    w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  end

  // Sequencer FSM with registered Result/Busy/Done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_opnd   <= '0;
      r_prod   <= '0;
      r_rem    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (Start) begin
            r_funct3 <= Funct3;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_cnt    <= '0;
            r_rem    <= '0;
            if (w_is_div_in) begin
              r_opnd <= w_mag_b;
              r_prod <= {{WIDTH{1'b0}}, w_mag_a};
            end else begin
              r_opnd <= w_mag_a;
              r_prod <= {{WIDTH{1'b0}}, w_mag_b};
            end
            if (w_div_zero || w_div_ovf) begin
              r_result <= w_special_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_funct3[2]) begin
            r_prod <= {{WIDTH{1'b0}}, w_quo_nxt};
            r_rem  <= w_rem_nxt;
          end else begin
            r_prod <= w_mul_nxt;
          end
          if (w_last) begin
            r_result <= f_finish(r_funct3, w_mul_nxt, w_quo_nxt,
                                 w_rem_nxt[WIDTH-1:0], r_sign_a, r_sign_b);
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          // Start is still high here while the CPU commits; it is ignored.
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Stall_CPU = ((r_state == S_IDLE) && Start) || (r_state == S_CALC);
  assign Result    = r_result;
  assign Busy      = r_busy;
  assign Done      = r_done;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed spec vectors, held-Start,
// mid-operation reset, back-to-back and randomized ops against a plain
// arithmetic reference model.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          Start;
  logic [2:0]    Funct3;
  logic [W-1:0]  OperandA;
  logic [W-1:0]  OperandB;
  logic [W-1:0]  Result;
  logic          Busy;
  logic          Done;
  logic          Stall_CPU;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Funct3(Funct3),
    .OperandA(OperandA), .OperandB(OperandB), .Result(Result),
    .Busy(Busy), .Done(Done), .Stall_CPU(Stall_CPU)
  );

  always #5 clk = ~clk;

  // Directed vectors: opcode, A, B, expected result, expected Done cycle.
  logic [2:0]  d_f3  [14] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101,
                              3'b111, 3'b100, 3'b110, 3'b100, 3'b110, 3'b101, 3'b111};
  logic [31:0] d_a   [14] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd100, 32'd100, 32'd5, 32'd5,
                              32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5};
  logic [31:0] d_b   [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                              32'd3, 32'd3, 32'd7, 32'd7, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
  logic [31:0] d_exp [14] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                              32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'h0000_000E, 32'h0000_0002,
                              32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0000_0000,
                              32'hFFFF_FFFF, 32'h0000_0005};
  int          d_lat [14] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1, 1, 1};

  // RISC-V M-extension semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                             input logic [31:0] a, input logic [31:0] b);
    longint     sa_l, sb_l, ua_l, ub_l;
    logic [63:0] p;
    int         ia, ib;
    logic       ovf;
    sa_l = longint'($signed(a));
    sb_l = longint'($signed(b));
    ua_l = longint'({32'd0, a});
    ub_l = longint'({32'd0, b});
    ia   = $signed(a);
    ib   = $signed(b);
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'b000: begin p = 64'(ua_l * ub_l); return p[31:0]; end
      3'b001: begin p = 64'(sa_l * sb_l); return p[63:32]; end
      3'b010: begin p = 64'(sa_l * ub_l); return p[63:32]; end
      3'b011: begin p = 64'(ua_l * ub_l); return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drives one instruction (Start held until the DONE cycle has passed) and
  // records what was observed; callers compare.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int tail, input bit scramble,
                        output logic [31:0] res, output int done_cyc,
                        output int bad_stall, output int bad_busy, output int n_done);
    bit special;
    int lat;
    bit exp_stall, exp_busy;
    special   = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    lat       = special ? 1 : W + 1;
    res       = 'x;
    done_cyc  = -1;
    bad_stall = 0;
    bad_busy  = 0;
    n_done    = 0;
    Funct3    = f3;
    OperandA  = a;
    OperandB  = b;
    Start     = 1'b1;
    for (int c = 0; c <= lat + tail; c++) begin
      if (scramble && c >= 1) begin
        OperandA = $urandom;
        OperandB = $urandom;
        Funct3   = 3'($urandom_range(0, 7));
      end
      #2;
      exp_stall = (c < lat);
      exp_busy  = !special && (c >= 1) && (c <= W);
      if (Stall_CPU !== exp_stall) bad_stall++;
      if (Busy !== exp_busy) bad_busy++;
      if (Done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = c;
          res      = Result;
        end
      end
      @(posedge clk); #1;
      if (c == lat) Start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    Start    = 1'b0;
    Funct3   = 3'b000;
    OperandA = '0;
    OperandB = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (Result !== 32'h0) begin n_bad++; $display("FAIL reset_result got=%h exp=%h", Result, 32'h0); end
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", Done); end
    n_cmp++; if (Stall_CPU !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", Stall_CPU); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] res;
    int dc, bs, bb, nd;
    for (int i = 0; i < 14; i++) begin
      run_op(d_f3[i], d_a[i], d_b[i], 2, 1'b0, res, dc, bs, bb, nd);
      n_cmp++; if (res !== d_exp[i]) begin n_bad++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, d_exp[i]); end
      n_cmp++; if (dc !== d_lat[i]) begin n_bad++; $display("FAIL dir%0d_done_cycle got=%0d exp=%0d", i, dc, d_lat[i]); end
      n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL dir%0d_done_pulses got=%0d exp=1", i, nd); end
      n_cmp++; if (bs !== 0) begin n_bad++; $display("FAIL dir%0d_stall_cycles_wrong got=%0d exp=0", i, bs); end
      n_cmp++; if (bb !== 0) begin n_bad++; $display("FAIL dir%0d_busy_cycles_wrong got=%0d exp=0", i, bb); end
      n_cmp++; if (Result !== d_exp[i]) begin n_bad++; $display("FAIL dir%0d_result_hold got=%h exp=%h", i, Result, d_exp[i]); end
    end
  endtask

  task automatic test_start_held();
    logic [31:0] res;
    int dc, bs, bb, nd;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1, 1'b0, res, dc, bs, bb, nd);
    n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL held_done_pulses got=%0d exp=1", nd); end
    n_cmp++; if (bs !== 0) begin n_bad++; $display("FAIL held_stall_cycles_wrong got=%0d exp=0", bs); end
    @(posedge clk); #1;
    run_op(3'b000, 32'd3, 32'd4, 2, 1'b0, res, dc, bs, bb, nd);
    n_cmp++; if (res !== 32'h0000_000C) begin n_bad++; $display("FAIL held_mul3x4 got=%h exp=%h", res, 32'hC); end
    n_cmp++; if (dc !== 33) begin n_bad++; $display("FAIL held_mul3x4_done_cycle got=%0d exp=33", dc); end
  endtask

  task automatic test_reset_mid();
    int seen;
    Funct3   = 3'b101;
    OperandA = 32'd1000;
    OperandB = 32'd7;
    Start    = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
    end
    #2;
    n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before got=%b exp=1", Busy); end
    rst_n = 1'b0;
    Start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2;
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b exp=0", Busy); end
    n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got=%b exp=0", Done); end
    n_cmp++; if (Stall_CPU !== 1'b0) begin n_bad++; $display("FAIL rstmid_stall got=%b exp=0", Stall_CPU); end
    n_cmp++; if (Result !== 32'h0) begin n_bad++; $display("FAIL rstmid_result got=%h exp=%h", Result, 32'h0); end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #3;
      if (Done === 1'b1) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstmid_stray_done got=%0d exp=0", seen); end
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int count, input bit back_to_back);
    logic [31:0] res, a, b, exp;
    logic [2:0]  f3;
    int dc, bs, bb, nd, mode, exp_dc;
    bit special;
    for (int i = 0; i < count; i++) begin
      f3   = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 9);
      a    = $urandom;
      b    = $urandom;
      if (mode == 0) b = 32'd0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
      else if (mode == 3) b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
      special = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      exp_dc  = special ? 1 : 33;
      exp     = ref_result(f3, a, b);
      run_op(f3, a, b, back_to_back ? 0 : $urandom_range(0, 2), 1'b1, res, dc, bs, bb, nd);
      n_cmp++; if (res !== exp) begin n_bad++; $display("FAIL rnd%0d_result f3=%0d a=%h b=%h got=%h exp=%h", i, f3, a, b, res, exp); end
      n_cmp++; if (dc !== exp_dc) begin n_bad++; $display("FAIL rnd%0d_done_cycle got=%0d exp=%0d", i, dc, exp_dc); end
      n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL rnd%0d_done_pulses got=%0d exp=1", i, nd); end
      n_cmp++; if (bs !== 0) begin n_bad++; $display("FAIL rnd%0d_stall_cycles_wrong got=%0d exp=0", i, bs); end
      n_cmp++; if (bb !== 0) begin n_bad++; $display("FAIL rnd%0d_busy_cycles_wrong got=%0d exp=0", i, bb); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_held();
    test_reset_mid();
    test_random(8, 1'b1);
    test_random(40, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle sequencer for the RV32IM M-extension: MUL/MULH/MULHSU/MULHU by iterative shift-add, DIV/DIVU/REM/REMU by iterative restoring division.
Sits beside the single-cycle ALU.
Freezes the PC/register-file write via Stall_CPU until the result is ready.
Handles RISC-V divide-by-zero and signed-overflow results in one cycle.

Parameters:
WIDTH, 32, operand/result width; also the iteration count.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset; synchronous, active-low.
Start  input  1  M-type instruction decoded this cycle (level, held by the CPU while stalled).
Funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
OperandA  input  WIDTH  rs1 value.
OperandB  input  WIDTH  rs2 value.
Result  output  WIDTH  rd write data; registered.
Busy  output  1  registered; high while state==CALC.
Done  output  1  registered; one-cycle result-valid pulse.
Stall_CPU  output  1  combinational; (state==IDLE & Start) | state==CALC.

Behaviour:
- Reset: when rst_n=0 at a rising edge, state=IDLE, Result=0, Busy=0, Done=0, counter=0, and all internal accumulators are cleared.
- Reset mid-operation aborts the operation; no Done pulse is produced.
- States: IDLE, CALC, DONE.
- IDLE: on an edge with Start=1, latch Funct3, the operands, and the operand signs.
  - Special case, go to DONE directly: DIV/REM with B==0, or DIV/REM with A==0x80000000 and B==0xFFFFFFFF.
  - Otherwise go to CALC with counter=0.
- CALC: one iteration per edge on the unsigned magnitudes. After WIDTH iterations (counter==WIDTH-1), go to DONE and apply sign correction.
  - Multiply: 2*WIDTH-bit unsigned product of |A|, |B|.
    - MUL: low word; sign does not affect the low word.
    - MULH: high word, negated if signA^signB.
    - MULHSU: high word of A (signed) times B (unsigned); negated if signA.
    - MULHU: high word, unsigned.
  - Divide: quotient and remainder of |A|/|B|.
    - DIV: quotient negated if signA^signB.
    - REM: remainder negated if signA. Remainder sign follows the dividend.
    - DIVU/REMU: unsigned operands, no correction.
- Special results:
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give A.
  - Signed overflow: DIV gives 0x80000000; REM gives 0.
- DONE: Result is written at the edge entering DONE. Done=1 for exactly this cycle and Stall_CPU=0, so the CPU commits rd and advances the PC at the next edge. The state then returns to IDLE unconditionally; Start seen in DONE is ignored and never restarts the operation.
- Timing, with cycle 0 the first cycle Start=1 in IDLE:
  - Normal ops: Stall_CPU high in cycles 0..WIDTH; Busy high in cycles 1..WIDTH; Done high in cycle WIDTH+1.
  - Special cases: Stall_CPU high in cycle 0 only; Done high in cycle 1.
- Result holds its value until the next DONE entry.
- Operand or Funct3 changes during CALC have no effect, because the values were latched in IDLE.
- Start arriving in the cycle immediately after DONE (back-to-back M instructions) is accepted normally from IDLE.
- Accumulator widths: 2*WIDTH product register. WIDTH+1 partial-remainder register for the divider's subtract-compare. Counter is $clog2(WIDTH) bits.

Test Plan:
1. MUL, A=7, B=0xFFFFFFFD, Start held until Done.
   - Result=0xFFFFFFEB.
   - Stall_CPU high in cycles 0..32; Busy high in cycles 1..32; Done high only in cycle 33.
2. High-word multiplies:
   - MULH 0x80000000×0x80000000 → 0x40000000.
   - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
3. Divides, each with latency 33:
   - DIV 0xFFFFFFEC/3 → 0xFFFFFFFA.
   - REM 0xFFFFFFEC/3 → 0xFFFFFFFE.
   - DIVU 100/7 → 0x0000000E.
   - REMU 100/7 → 0x00000002.
4. Divide-by-zero and overflow, each with Done in cycle 1 and Stall_CPU only in cycle 0:
   - DIV 5/0 → 0xFFFFFFFF.
   - REM 5/0 → 0x00000005.
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
   - REM of the same operands → 0x00000000.
5. Start held high through DONE, then deasserted.
   - Exactly one Done pulse; state back in IDLE.
   - A fresh Start two cycles later with MUL 3×4 gives Result=0x0000000C after 33 cycles.
6. rst_n=0 for one edge at CALC cycle 10.
   - Next cycle: Busy=0, Done=0, Stall_CPU=0 with Start low, Result=0.
   - No Done pulse appears within the following 40 cycles.
